hp_multiplier: RTL and testbench
================================

HP_MULTIPLIER -- requirements
Module: hp_multiplier

Interface
REQ-001 SHALL have no parameters; the block is fixed at IEEE 754 binary16 (1 sign, 5 exponent with bias 15, 10 fraction bits).
REQ-002 SHALL have port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst`: input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port `hp_inA`: input, 16 bits, operand A in binary16.
REQ-005 SHALL have port `hp_inB`: input, 16 bits, operand B in binary16.
REQ-006 SHALL have port `hp_product`: output, 16 bits, registered binary16 product A*B.
REQ-007 SHALL have port `Exceptions`: output, 2 bits, registered status: 00 none, 01 overflow, 10 underflow, 11 invalid (NaN result).

Function
REQ-008 SHALL sample `hp_inA`/`hp_inB` on every rising edge of `clk` and present the corresponding `hp_product`/`Exceptions` after that same edge (latency 1 cycle, throughput 1 per cycle, no handshake).
REQ-009 SHALL compute the result combinationally from the current inputs and register it; the outputs SHALL hold their value while the inputs are unchanged.
REQ-010 SHALL decode each operand as one of: NaN (exp=31, frac!=0), Inf (exp=31, frac=0), zero (exp=0, frac=0), denormal (exp=0, frac!=0), normal.
REQ-011 SHALL treat denormal inputs as signed zero (flush-to-zero on input).
REQ-012 SHALL produce result sign = signA XOR signB for all non-NaN results.
REQ-013 Special-case precedence, highest first:
- any NaN operand, or Inf*zero: 0x7E00, `Exceptions`=11;
- any Inf operand: signed Inf (exp 31, frac 0), `Exceptions`=00;
- any zero/denormal operand: signed zero, `Exceptions`=00;
- otherwise: the normal path.
REQ-014 Normal path, significands: form 11-bit significands (hidden 1) and take the 22-bit product.
REQ-015 Normal path, exponent: unbiased sum expA+expB-15, computed in a signed width of at least 7 bits.
REQ-016 Normal path, normalisation: if product bit 21 is set, shift right by 1 and increment the exponent.
REQ-017 Normal path, rounding: round to nearest, ties to even, using guard, round and sticky bits from the discarded product bits.
REQ-018 Normal path, mantissa carry-out: a rounding carry out of the mantissa SHALL renormalise (fraction becomes 0, exponent +1).
REQ-019 Overflow: final biased exponent >= 31 SHALL give signed Inf, `Exceptions`=01.
REQ-020 Underflow: final biased exponent <= 0 SHALL give signed zero (no denormal outputs), `Exceptions`=10.
REQ-021 SHALL give `Exceptions`=00 for every other result, including exact and inexact normal results.
REQ-022 SHALL be fully synthesizable with no latches; unused product bits SHALL only feed the sticky bit.

Reset
REQ-023 While `rst`=1, asynchronously and regardless of `clk`, SHALL force `hp_product`=0x0000 and `Exceptions`=00.
REQ-024 SHALL resume normal sampling on the first rising `clk` edge after `rst` deasserts.
REQ-025 SHALL discard any result in flight when reset is asserted mid-operation; no stale value may appear after reset.

Verification
REQ-026 Normal products (one edge after the inputs are applied):
- 0x4100 (2.5) * 0x4400 (4) -> 0x4900, 00;
- 0x4100 * 0xC400 -> 0xC900, 00;
- 0xC100 * 0xC400 -> 0x4900, 00;
- 0x3E00 (1.5) * 0x3E00 -> 0x4080 (2.25), 00.
REQ-027 Rounding tie: 0x4100 * 0x44E6 -> 0x4A20 (RNE tie to even), 00.
REQ-028 Specials:
- 0x7C00 * 0x44E6 -> 0x7C00, 00;
- 0xFC00 * 0x0000 -> 0x7E00, 11;
- 0x7D04 * 0x44E6 -> 0x7E00, 11;
- 0x0000 * 0x44E6 -> 0x0000, 00.
REQ-029 Denormal and underflow:
- 0x011E * 0x44E6 -> 0x0000, 00;
- 0x811E * 0x0000 -> 0x8000, 00;
- 0x0500 * 0x0906 -> 0x0000, 10.
REQ-030 Overflow: 0x7BFF * 0x7BFF -> 0x7C00, 01.
REQ-031 Reset: assert `rst` mid-stream with nonzero outputs -> outputs become 0x0000/00 immediately without a clock edge; after deassert, the next edge loads the current product.

Source files
------------

// File: rtl/hp_multiplier.sv
// hp_multiplier: single-cycle IEEE 754 binary16 multiplier with registered
// product and exception status. Denormal operands are flushed to signed zero,
// results are rounded to nearest-even, and tiny results flush to zero.
`timescale 1ns/1ps
module hp_multiplier (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] hp_inA,
   input  logic [15:0] hp_inB,
   output logic [15:0] hp_product,
   output logic [1:0]  Exceptions
);

   // Round-to-nearest-even on an 11-bit significand; bit 11 of the result is
   // the carry out that forces renormalisation.
   function automatic logic [11:0] round_rne(input logic [10:0] mant,
                                             input logic        guard,
                                             input logic        rnd,
                                             input logic        sticky);
      logic up;
      up = guard & (rnd | sticky | mant[0]);
      return {1'b0, mant} + {11'd0, up};
   endfunction

   logic               sign_a, sign_b, sign_r;
   logic [4:0]         exp_a, exp_b;
   logic [9:0]         frac_a, frac_b;
   logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic [21:0]        prod;
   logic signed [7:0]  exp_sum, exp_norm, exp_fin;
   logic [10:0]        mant;
   logic               guard, rnd, sticky;
   logic [11:0]        mant_rnd;
   logic [9:0]         frac_r;
   logic [15:0]        prod_nxt;
   logic [1:0]         exc_nxt;
   logic [15:0]        prod_p0;
   logic [1:0]         exc_p0;

   assign sign_a = hp_inA[15];
   assign sign_b = hp_inB[15];
   assign exp_a  = hp_inA[14:10];
   assign exp_b  = hp_inB[14:10];
   assign frac_a = hp_inA[9:0];
   assign frac_b = hp_inB[9:0];
   assign sign_r = sign_a ^ sign_b;

   // Operand classification; exponent 0 covers both true zero and flushed denormals.
   assign nan_a  = (exp_a == 5'h1f) && (frac_a != 10'd0);
   assign nan_b  = (exp_b == 5'h1f) && (frac_b != 10'd0);
   assign inf_a  = (exp_a == 5'h1f) && (frac_a == 10'd0);
   assign inf_b  = (exp_b == 5'h1f) && (frac_b == 10'd0);
   assign zero_a = (exp_a == 5'd0);
   assign zero_b = (exp_b == 5'd0);

   // Combinational datapath: significand product, normalisation, rounding, specials.
   always_comb begin
      prod     = {11'd0, 1'b1, frac_a} * {11'd0, 1'b1, frac_b};
      exp_sum  = $signed({3'b000, exp_a}) + $signed({3'b000, exp_b}) - 8'sd15;
      mant     = prod[20:10];
      guard    = prod[9];
      rnd      = prod[8];
      sticky   = |prod[7:0];
      exp_norm = exp_sum;
      if (prod[21]) begin
         mant     = prod[21:11];
         guard    = prod[10];
         rnd      = prod[9];
         sticky   = |prod[8:0];
         exp_norm = exp_sum + 8'sd1;
      end
      mant_rnd = round_rne(mant, guard, rnd, sticky);
      // A carry out leaves 0x800, so bits [10:1] are the (zero) fraction.
      frac_r   = mant_rnd[11] ? mant_rnd[10:1] : mant_rnd[9:0];
      exp_fin  = mant_rnd[11] ? exp_norm + 8'sd1 : exp_norm;

      prod_nxt = {sign_r, exp_fin[4:0], frac_r};
      exc_nxt  = 2'b00;
      if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
         prod_nxt = 16'h7E00;
         exc_nxt  = 2'b11;
      end else if (inf_a || inf_b) begin
         prod_nxt = {sign_r, 5'h1f, 10'd0};
      end else if (zero_a || zero_b) begin
         prod_nxt = {sign_r, 15'd0};
      end else if (exp_fin >= 8'sd31) begin
         prod_nxt = {sign_r, 5'h1f, 10'd0};
         exc_nxt  = 2'b01;
      end else if (exp_fin <= 8'sd0) begin
         prod_nxt = {sign_r, 15'd0};
         exc_nxt  = 2'b10;
      end
   end

   // Output register: one-cycle latency, cleared immediately by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_p0 <= 16'h0000;
         exc_p0  <= 2'b00;
      end else begin
         prod_p0 <= prod_nxt;
         exc_p0  <= exc_nxt;
      end
   end

   assign hp_product = prod_p0;
   assign Exceptions = exc_p0;

endmodule

// File: tb/tb_hp_multiplier.sv
// Testbench for hp_multiplier: directed vectors, reset behaviour and
// randomized operands compared with an arithmetic reference model.
`timescale 1ns/1ps
module tb_hp_multiplier;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] hp_inA, hp_inB;
   logic [15:0] hp_product;
   logic [1:0]  Exceptions;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hp_multiplier dut (
      .clk        (clk),
      .rst        (rst),
      .hp_inA     (hp_inA),
      .hp_inB     (hp_inB),
      .hp_product (hp_product),
      .Exceptions (Exceptions)
   );

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: observed 0x%04h, expected 0x%04h", tag, obs, expv);
      end
   endtask

   // Reference: exact integer product of significands, rounded by remainder
   // comparison against one half ulp. Returns {exceptions, product}.
   function automatic logic [17:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      int     ea, eb, fa, fb, sh, e;
      longint p, q, rem, half;
      logic   s;
      logic [4:0] e5;
      logic [9:0] f10;
      ea = int'(a[14:10]); eb = int'(b[14:10]);
      fa = int'(a[9:0]);   fb = int'(b[9:0]);
      s  = a[15] ^ b[15];
      if ((ea == 31 && fa != 0) || (eb == 31 && fb != 0) ||
          (ea == 31 && eb == 0) || (eb == 31 && ea == 0))
         return {2'b11, 16'h7E00};
      if (ea == 31 || eb == 31) return {2'b00, s, 5'h1f, 10'h000};
      if (ea == 0 || eb == 0)   return {2'b00, s, 15'h0000};
      p    = longint'(1024 + fa) * longint'(1024 + fb);
      sh   = (p >= 64'd2097152) ? 11 : 10;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      e = ea + eb - 15 + (sh - 10);
      if (q == 2048) begin
         q = 1024;
         e = e + 1;
      end
      if (e >= 31) return {2'b01, s, 5'h1f, 10'h000};
      if (e <= 0)  return {2'b10, s, 15'h0000};
      e5  = e[4:0];
      f10 = q[9:0];
      return {2'b00, s, e5, f10};
   endfunction

   task automatic dir_vec(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] want_p, input logic [1:0] want_e,
                          input string tag);
      @(negedge clk);
      hp_inA = a;
      hp_inB = b;
      @(posedge clk);
      #1;
      check_val({tag, " product"}, hp_product, want_p);
      check_val({tag, " exc"}, {14'd0, Exceptions}, {14'd0, want_e});
   endtask

   task automatic rnd_vec(input logic [15:0] a, input logic [15:0] b);
      logic [17:0] r;
      r = ref_mul(a, b);
      @(negedge clk);
      hp_inA = a;
      hp_inB = b;
      @(posedge clk);
      #1;
      check_val($sformatf("rand %04h*%04h product", a, b), hp_product, r[15:0]);
      check_val($sformatf("rand %04h*%04h exc", a, b), {14'd0, Exceptions}, {14'd0, r[17:16]});
   endtask

   initial begin
      logic [15:0] ra, rb;
      rst    = 1'b1;
      hp_inA = 16'h4100;
      hp_inB = 16'h4400;
      #12;
      check_val("reset product", hp_product, 16'h0000);
      check_val("reset exc", {14'd0, Exceptions}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      // Normal products and rounding tie
      dir_vec(16'h4100, 16'h4400, 16'h4900, 2'b00, "2.5*4");
      dir_vec(16'h4100, 16'hC400, 16'hC900, 2'b00, "2.5*-4");
      dir_vec(16'hC100, 16'hC400, 16'h4900, 2'b00, "-2.5*-4");
      dir_vec(16'h3E00, 16'h3E00, 16'h4080, 2'b00, "1.5*1.5");
      // Inputs unchanged: output must hold
      @(posedge clk);
      #1;
      check_val("hold product", hp_product, 16'h4080);
      dir_vec(16'h4100, 16'h44E6, 16'h4A20, 2'b00, "rne tie");
      // Specials
      dir_vec(16'h7C00, 16'h44E6, 16'h7C00, 2'b00, "inf*x");
      dir_vec(16'hFC00, 16'h0000, 16'h7E00, 2'b11, "inf*0");
      dir_vec(16'h7D04, 16'h44E6, 16'h7E00, 2'b11, "nan*x");
      dir_vec(16'h0000, 16'h44E6, 16'h0000, 2'b00, "0*x");
      dir_vec(16'h7C00, 16'h811E, 16'h7E00, 2'b11, "inf*denorm");
      // Denormal flush and underflow
      dir_vec(16'h011E, 16'h44E6, 16'h0000, 2'b00, "denorm*x");
      dir_vec(16'h811E, 16'h0000, 16'h8000, 2'b00, "-denorm*0");
      dir_vec(16'h0500, 16'h0906, 16'h0000, 2'b10, "underflow");
      dir_vec(16'h8500, 16'h0906, 16'h8000, 2'b10, "neg underflow");
      // Overflow
      dir_vec(16'h7BFF, 16'h7BFF, 16'h7C00, 2'b01, "overflow");
      dir_vec(16'hFBFF, 16'h7BFF, 16'hFC00, 2'b01, "neg overflow");

      // Asynchronous reset mid-stream
      dir_vec(16'h4100, 16'h4400, 16'h4900, 2'b00, "pre-reset");
      #2;
      rst = 1'b1;
      #1;
      check_val("async rst product", hp_product, 16'h0000);
      check_val("async rst exc", {14'd0, Exceptions}, 16'h0000);
      hp_inA = 16'h3E00;
      hp_inB = 16'h3E00;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("post-rst idle product", hp_product, 16'h0000);
      @(posedge clk);
      #1;
      check_val("post-rst product", hp_product, 16'h4080);
      check_val("post-rst exc", {14'd0, Exceptions}, 16'h0000);

      // Randomized: fully random bit patterns, then mostly-normal operands
      for (int i = 0; i < 300; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rnd_vec(ra, rb);
      end
      for (int i = 0; i < 600; i++) begin
         ra = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
         rb = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
         rnd_vec(ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
